// File: rtl/plot_sink.sv
// plot_sink - buffers pixel plot requests, clips them and turns them into framebuffer writes; also runs full-screen clears.
// Optional build macro PLOT_SINK_STATS_EN adds clip_count/stall_count outputs.
module plot_sink #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 19,
  parameter int COLOUR_W   = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            plot_enable,
  input  logic [9:0]                      x,
  input  logic [8:0]                      y,
  input  logic [COLOUR_W-1:0]             colour,
  output logic                            plot_ready,
  input  logic                            clear_req,
  input  logic [COLOUR_W-1:0]             clear_colour,
  output logic                            clear_done,
  output logic                            fb_wren,
  output logic [ADDR_W-1:0]               fb_addr,
  output logic [COLOUR_W-1:0]             fb_data,
  input  logic                            fb_busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
`ifdef PLOT_SINK_STATS_EN
  output logic [15:0]                     clip_count,
  output logic [15:0]                     stall_count,
`endif
  output logic                            idle
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = 10 + 9 + COLOUR_W;

  localparam logic [9:0]        X_LIM      = 10'(H_RES);
  localparam logic [8:0]        Y_LIM      = 9'(V_RES);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL   = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR
  } state_e;

  state_e                state_q;
  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [LVL_W-1:0]      level_q;
  logic [LVL_W-1:0]      level_d;
  logic                  clear_pending_q;
  logic [COLOUR_W-1:0]   clear_colour_q;
  logic [ADDR_W-1:0]     clear_addr_q;
  logic                  fb_wren_q;
  logic [ADDR_W-1:0]     fb_addr_q;
  logic [COLOUR_W-1:0]   fb_data_q;
  logic                  clear_done_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  in_range;
  logic                  handshake;
  logic                  push;
  logic                  pop;
  logic                  clear_start;
  logic [ENTRY_W-1:0]    head;
  logic [9:0]            head_x;
  logic [8:0]            head_y;
  logic [COLOUR_W-1:0]   head_c;
  logic [ADDR_W-1:0]     pixel_addr;

  assign fifo_full  = (level_q == FULL_LVL);
  assign fifo_empty = (level_q == '0);

  // Readiness depends only on registered state, so a drawer can never loop through it.
  assign plot_ready  = !fifo_full && (state_q != ST_CLEAR) && !clear_pending_q;
  assign in_range    = (x < X_LIM) && (y < Y_LIM);
  assign handshake   = plot_enable && plot_ready;
  assign push        = handshake && in_range;
  assign pop         = (state_q == ST_DRAIN) && !fb_busy && !fifo_empty;
  assign clear_start = clear_req && !clear_pending_q && (state_q != ST_CLEAR);

  assign head       = mem_q[rd_ptr_q];
  assign head_x     = head[ENTRY_W-1 -: 10];
  assign head_y     = head[COLOUR_W +: 9];
  assign head_c     = head[COLOUR_W-1:0];
  assign pixel_addr = ADDR_W'(head_y) * ROW_STRIDE + ADDR_W'(head_x);

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push && pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {x, y, colour};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      clear_pending_q <= 1'b0;
      clear_colour_q  <= '0;
      clear_addr_q    <= '0;
      fb_wren_q       <= 1'b0;
      fb_addr_q       <= '0;
      fb_data_q       <= '0;
      clear_done_q    <= 1'b0;
    end else begin
      level_q      <= level_d;
      fb_wren_q    <= 1'b0;
      clear_done_q <= 1'b0;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (clear_start) begin
        clear_pending_q <= 1'b1;
        clear_colour_q  <= clear_colour;
      end

      case (state_q)
        ST_IDLE: begin
          // Clear waits for the last pixel write to leave so plots always land first.
          if (clear_pending_q && fifo_empty && !fb_wren_q) begin
            state_q      <= ST_CLEAR;
            clear_addr_q <= '0;
          end else if (!fifo_empty) begin
            state_q <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (pop) begin
            fb_wren_q <= 1'b1;
            fb_addr_q <= pixel_addr;
            fb_data_q <= head_c;
          end
          if (level_d == '0) begin
            state_q <= ST_IDLE;
          end
        end

        ST_CLEAR: begin
          if (!fb_busy) begin
            fb_wren_q <= 1'b1;
            fb_addr_q <= clear_addr_q;
            fb_data_q <= clear_colour_q;
            if (clear_addr_q == LAST_ADDR) begin
              clear_done_q    <= 1'b1;
              clear_pending_q <= 1'b0;
              state_q         <= ST_IDLE;
            end else begin
              clear_addr_q <= clear_addr_q + ADDR_W'(1);
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fb_wren    = fb_wren_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign clear_done = clear_done_q;
  assign fifo_level = level_q;
  assign idle       = (state_q == ST_IDLE) && fifo_empty && !fb_wren_q && !clear_pending_q;

`ifdef PLOT_SINK_STATS_EN
  logic [15:0] clip_count_q;
  logic [15:0] stall_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      clip_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      if (handshake && !in_range && (clip_count_q != 16'hFFFF)) begin
        clip_count_q <= clip_count_q + 16'd1;
      end
      if (plot_enable && !plot_ready && (stall_count_q != 16'hFFFF)) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  assign clip_count  = clip_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
